// File: rtl/his_reader_peak.sv
// Histogram read-side sweeper: streams bins 0..NUM_BINS-1 through a 2-entry skid buffer and tracks the peak bin.
// Optional HIS_CLEAR_ON_READ_EN: clears each bin in the cycle it is handed downstream.
module his_reader_peak #(
    parameter int NP       = 10,
    parameter int PEAK_MAX = 21,
    parameter int NUM_BINS = 1024
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    output logic                rd_en,
    output logic [NP-1:0]       rd_addr,
    input  logic [PEAK_MAX-1:0] rd_data,
    output logic                bin_valid,
    input  logic                bin_ready,
    output logic [NP-1:0]       bin_addr,
    output logic [PEAK_MAX-1:0] bin_count,
    output logic                bin_last,
    output logic                busy,
    output logic                done,
    output logic [NP-1:0]       peak_addr,
    output logic [PEAK_MAX-1:0] peak_count,
    output logic                clr_en,
    output logic [NP-1:0]       clr_addr
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

    localparam logic [NP-1:0] LAST_ADDR = NP'(NUM_BINS - 1);

    state_t              state_q;
    logic [NP-1:0]       ptr_q;
    logic                infl_q;
    logic [NP-1:0]       tag_q;
    logic [NP-1:0]       fa_q [2];
    logic [PEAK_MAX-1:0] fc_q [2];
    logic                wr_q;
    logic                rd_q;
    logic [1:0]          cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [NP-1:0]       pk_addr_q;
    logic [PEAK_MAX-1:0] pk_cnt_q;

    logic                hs;
    logic [1:0]          occ;
    logic [1:0]          occ_d;

    // A slot freed by this cycle's transfer may be reused, otherwise a
    // ready-high stream could only sustain one bin every other cycle.
    always_comb begin
        bin_valid = (cnt_q != 2'd0);
        bin_addr  = fa_q[rd_q];
        bin_count = fc_q[rd_q];
        bin_last  = bin_valid && (fa_q[rd_q] == LAST_ADDR);
        hs        = bin_valid && bin_ready;
        occ       = cnt_q + {1'b0, infl_q};
        occ_d     = occ - {1'b0, hs};
        rd_en     = (state_q == ST_READ) && (occ_d < 2'd2);
        rd_addr   = ptr_q;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign peak_addr  = pk_addr_q;
    assign peak_count = pk_cnt_q;

`ifdef HIS_CLEAR_ON_READ_EN
    assign clr_en   = hs;
    assign clr_addr = bin_addr;
`else
    assign clr_en   = 1'b0;
    assign clr_addr = '0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            infl_q    <= 1'b0;
            tag_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                fa_q[i] <= '0;
                fc_q[i] <= '0;
            end
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pk_addr_q <= '0;
            pk_cnt_q  <= '0;
        end else begin
            infl_q <= rd_en;
            if (rd_en) begin
                tag_q <= ptr_q;
            end

            // Read data lands one cycle after the strobe, tagged with its address.
            if (infl_q) begin
                fa_q[wr_q] <= tag_q;
                fc_q[wr_q] <= rd_data;
                wr_q       <= ~wr_q;
                if (rd_data > pk_cnt_q) begin
                    pk_cnt_q  <= rd_data;
                    pk_addr_q <= tag_q;
                end
            end
            if (hs) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, hs};

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_READ;
                        busy_q    <= 1'b1;
                        ptr_q     <= '0;
                        pk_cnt_q  <= '0;
                        pk_addr_q <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_en) begin
                        if (ptr_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last bin is the final entry, so its transfer empties the buffer.
                    if (hs && bin_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
